multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Sequencer that performs wide additions (64*WORDS bits) by issuing one 64-bit word per clock to the team's existing combinational 64-bit carry-select adder.
- Sits on both sides of that adder: drives its a/b/carry_in and consumes its sum/carry_out.
- Chains the carry between words in a register.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- WORDS, 4, number of 64-bit words per operand; legal range 1..16.
- IDXW, $clog2(WORDS) (minimum 1), width of the word index counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operand request
- start_ready  output  1  high only in IDLE
- op_a  input  64*WORDS  operand A, word 0 in [63:0]
- op_b  input  64*WORDS  operand B
- carry_in  input  1  initial carry
- add_a  output  64  to the 64-bit adder's a
- add_b  output  64  to the 64-bit adder's b
- add_cin  output  1  to the 64-bit adder's carry_in
- add_sum  input  64  from the 64-bit adder's sum
- add_cout  input  1  from the 64-bit adder's carry_out
- res_valid  output  1  result available
- res_ready  input  1  result consumer ready
- res_sum  output  64*WORDS  full result
- res_carry_out  output  1  carry out of the top word
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous active-low and forces the reset state immediately, including mid-operation.
- Reset values: state=IDLE, idx=0, carry_reg=0, a_reg/b_reg=0, res_sum=0, res_carry_out=0, res_valid=0, busy=0, start_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid: capture op_a→a_reg, op_b→b_reg, carry_in→carry_reg, idx←0, go to RUN.
- RUN:
  - Combinational drive: add_a=a_reg word[idx], add_b=b_reg word[idx], add_cin=carry_reg.
  - Each clock edge: res_sum word[idx]←add_sum, carry_reg←add_cout, idx←idx+1.
  - When idx==WORDS-1: go to DONE and load res_carry_out←add_cout.
- DONE:
  - res_valid=1.
  - res_sum and res_carry_out are held stable until res_valid&&res_ready, then go to IDLE.
- Outputs outside RUN: add_a, add_b and add_cin are driven to 0 in IDLE and DONE.
- Results after handshake: res_sum and res_carry_out keep their last values until overwritten by the next operation.
- Latency: acceptance in cycle 0; RUN occupies cycles 1..WORDS; res_valid is high from cycle WORDS+1.
- Throughput: with res_ready tied high, one operation every WORDS+2 cycles.
- No overlap: start_valid is ignored while busy, and operand inputs are sampled only at acceptance.
- WORDS=1: RUN lasts exactly one cycle.
- Arithmetic: modulo 2^(64*WORDS) plus carry-out. The adder is purely combinational, so the sequencer samples add_sum/add_cout in the same cycle it drives the operands.
- Reset during RUN or DONE: the partial result is discarded. The next accepted operation must be correct with no residue from the aborted one.
- res_ready asserted while res_valid=0 has no effect.

Optional Feature:
- Macro: MWADD_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured with the operands at acceptance.
  - If sub=1: add_b=~b_reg word[idx] and the initial carry_reg=1; carry_in is ignored.
  - Result is A-B. res_carry_out=1 means no borrow.
- When undefined:
  - No sub port; addition only.

Test Plan:
1. WORDS=4, op_a=all ones, op_b=1, carry_in=0, res_ready=1 → res_sum=0, res_carry_out=1, res_valid in cycle 5 after acceptance.
2. op_a word0=64'hFFFF_FFFF_FFFF_FFFF (other words 0), op_b=0, carry_in=1 → word0=0, word1=1, words2..3=0, res_carry_out=0; check add_cin=1 on the word-1 issue cycle.
3. Backpressure: res_ready=0 for 10 cycles after res_valid → res_valid stays 1, res_sum stable, start_ready=0, a start_valid pulse is ignored; res_ready=1 → IDLE next cycle.
4. Assert rst_n low during RUN at idx=2 → immediately IDLE, res_valid=0, busy=0; then op_a=3, op_b=4 → res_sum=7, res_carry_out=0.
5. MWADD_SUB_EN defined, sub=1, op_a=5, op_b=7 → res_sum=2^256-2, res_carry_out=0. Then op_a=7, op_b=5 → res_sum=2, res_carry_out=1.
6. start_valid held high, res_ready=1, three random operand pairs → three correct results compared against a 257-bit reference sum; consecutive acceptances spaced exactly 6 cycles apart.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Wide adder sequencer: streams 64*WORDS-bit operands one word per clock through an
// external combinational 64-bit adder. Define MWADD_SUB_EN to add the subtract mode (port sub).
module multiword_add_sequencer #(
    parameter  int WORDS = 4,
    localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [64*WORDS-1:0]   op_a,
    input  logic [64*WORDS-1:0]   op_b,
    input  logic                  carry_in,
`ifdef MWADD_SUB_EN
    input  logic                  sub,
`endif
    output logic [63:0]           add_a,
    output logic [63:0]           add_b,
    output logic                  add_cin,
    input  logic [63:0]           add_sum,
    input  logic                  add_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [64*WORDS-1:0]   res_sum,
    output logic                  res_carry_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   idx;
    logic              carry_reg;
    logic [63:0]       a_reg    [WORDS];
    logic [63:0]       b_reg    [WORDS];
    logic [63:0]       res_word [WORDS];
    logic [63:0]       b_word;
    logic              last_word;
    logic              accept;

    assign last_word = (idx == IDXW'(WORDS - 1));
    assign accept    = (state == IDLE) && start_valid;

`ifdef MWADD_SUB_EN
    logic sub_reg;

    // Subtraction is A + ~B + 1: invert each B word and seed the carry chain with 1.
    assign b_word = sub_reg ? ~b_reg[idx] : b_reg[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_reg <= 1'b0;
        end else if (accept) begin
            sub_reg <= sub;
        end
    end
`else
    assign b_word = b_reg[idx];
`endif

    for (genvar w = 0; w < WORDS; w++) begin : g_res
        assign res_sum[64*w +: 64] = res_word[w];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        add_a       = 64'd0;
        add_b       = 64'd0;
        add_cin     = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                add_a   = a_reg[idx];
                add_b   = b_word;
                add_cin = carry_reg;
                if (last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The adder is combinational: its sum for the word driven this cycle is captured at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            carry_reg     <= 1'b0;
            res_carry_out <= 1'b0;
            for (int w = 0; w < WORDS; w++) begin
                a_reg[w]    <= 64'd0;
                b_reg[w]    <= 64'd0;
                res_word[w] <= 64'd0;
            end
        end else if (accept) begin
            idx <= '0;
            for (int w = 0; w < WORDS; w++) begin
                a_reg[w] <= op_a[64*w +: 64];
                b_reg[w] <= op_b[64*w +: 64];
            end
`ifdef MWADD_SUB_EN
            carry_reg <= sub ? 1'b1 : carry_in;
`else
            carry_reg <= carry_in;
`endif
        end else if (state == RUN) begin
            res_word[idx] <= add_sum;
            carry_reg     <= add_cout;
            idx           <= idx + IDXW'(1);
            if (last_word) begin
                res_carry_out <= add_cout;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (WORDS=4) with a behavioural 64-bit adder
// attached; subtract cases are included when MWADD_SUB_EN is defined.
module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 64 * WORDS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_valid;
    logic           start_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           carry_in;
    logic           sub;
    logic [63:0]    add_a;
    logic [63:0]    add_b;
    logic           add_cin;
    logic [63:0]    add_sum;
    logic           add_cout;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_sum;
    logic           res_carry_out;
    logic           busy;

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .carry_in      (carry_in),
`ifdef MWADD_SUB_EN
        .sub           (sub),
`endif
        .add_a         (add_a),
        .add_b         (add_b),
        .add_cin       (add_cin),
        .add_sum       (add_sum),
        .add_cout      (add_cout),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_sum       (res_sum),
        .res_carry_out (res_carry_out),
        .busy          (busy)
    );

    // The team's combinational adder, modelled behaviourally.
    assign {add_cout, add_sum} = 65'(add_a) + 65'(add_b) + 65'(add_cin);

    always #5 clk = ~clk;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic [W:0]   exp_q[$];
    int           acc_q[$];
    logic         prev_valid = 1'b0;
    logic         spacing_on = 1'b0;
    int           spacing_prev = -1;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: acceptance times, result latency/spacing and scoreboard comparison.
    always @(negedge clk) begin
        if (rst_n) begin
            if (start_valid && start_ready) begin
                acc_q.push_back(cyc);
                if (spacing_on) begin
                    if (spacing_prev >= 0) chk("accept_spacing", (W+1)'(cyc - spacing_prev), (W+1)'(WORDS + 2));
                    spacing_prev = cyc;
                end
            end
            if (res_valid && !prev_valid) begin
                if (acc_q.size() == 0) chk("latency_no_accept", 1, 0);
                else chk("latency", (W+1)'(cyc - acc_q[0]), (W+1)'(WORDS + 1));
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {res_carry_out, res_sum}, '1);
                end else begin
                    chk("result", {res_carry_out, res_sum}, exp_q.pop_front());
                    if (acc_q.size() > 0) void'(acc_q.pop_front());
                end
            end
            prev_valid = res_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
        if ($urandom_range(0, 3) == 0) r = '1;
        return r;
    endfunction

    // Drive one operation from posedge+#1 and return at posedge+#1 just after acceptance.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic s, input logic hold);
        int n = 0;
        logic [W:0] e;
        op_a     = a;
        op_b     = b;
        carry_in = cin;
        sub      = s;
        if (s) e = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   e = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        while (!start_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("start_ready_timeout", 0, 1);
        exp_q.push_back(e);
        start_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) chk("res_valid_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] snap;
        logic [W-1:0] ones;
        ones        = '1;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        carry_in    = 1'b0;
        sub         = 1'b0;
        res_ready   = 1'b1;
        #23;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res", {res_carry_out, res_sum}, 0);
        chk("rst_add_cin", add_cin, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // All ones + 1 wraps to zero with carry out.
        issue(ones, 1, 1'b0, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk); #1;

        // Carry from word 0 into word 1.
        snap = '0;
        snap[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        issue(snap, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("w0_add_a", add_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w0_add_cin", add_cin, 1);
        @(posedge clk); @(negedge clk);
        chk("w1_add_cin", add_cin, 1);
        chk("w1_add_a", add_a, 0);
        wait_valid();
        @(posedge clk); #1;

        // Backpressure: result held, start ignored while DONE.
        res_ready = 1'b0;
        issue(rand_op(), rand_op(), 1'b1, 1'b0, 1'b0);
        wait_valid();
        snap = res_sum;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_sum_stable", res_sum, snap);
            chk("bp_start_ready", start_ready, 0);
            @(posedge clk); #1;
            start_valid = (i == 3);
            op_a = rand_op();
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", start_ready, 1);
        chk("bp_idle_busy", busy, 0);
        @(posedge clk); #1;

        // Asynchronous reset mid-RUN at idx=2, then a clean operation.
        issue(ones, 1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_start_ready", start_ready, 1);
        chk("abort_res", {res_carry_out, res_sum}, 0);
        void'(exp_q.pop_back());
        acc_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3, 4, 1'b0, 1'b0, 1'b0);
        wait_valid();
        @(posedge clk); #1;

`ifdef MWADD_SUB_EN
        issue(5, 7, 1'b0, 1'b1, 1'b0);
        wait_valid();
        @(posedge clk); #1;
        issue(7, 5, 1'b1, 1'b1, 1'b0);
        wait_valid();
        @(posedge clk); #1;
`endif

        // start_valid held high: back-to-back acceptances every WORDS+2 cycles.
        spacing_prev = -1;
        spacing_on   = 1'b1;
        for (int k = 0; k < 3; k++) issue(rand_op(), rand_op(), 1'(k == 1), 1'b0, 1'(k < 2));
        start_valid = 1'b0;
        wait_valid();
        @(posedge clk); #1;
        spacing_on = 1'b0;
        @(posedge clk); #1;

        // Random operations under random result backpressure.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    @(posedge clk); #1;
                    res_ready = 1'($urandom_range(0, 1));
                end
                res_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < 6; k++) issue(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

        for (int n = 0; n < 400 && exp_q.size() > 0; n++) @(posedge clk);
        #1;
        chk("drain", (W+1)'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
